// File: rtl/spi_pkg.sv
// Shared types and default opcodes for the SPI flash master.
package spi_pkg;
  localparam logic [7:0] OP_WR = 8'h20;
  localparam logic [7:0] OP_RD = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;
endpackage

// File: rtl/spi_byte_shifter.sv
// One-byte SPI shift engine: half-period divider, 16-edge SCK, SDO out, SDI in.
module spi_byte_shifter
  import spi_pkg::*;
#(
  parameter int HALF_DIV = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  mode_t      mode,
  input  logic       start,
  input  logic       sdi,
  output logic       done,
  output logic       sck,
  output logic       sdo,
  output logic [7:0] rx_byte
);
  logic       active_q, active_d;
  logic [7:0] div_q, div_d;
  logic [3:0] edge_q, edge_d;
  logic       sck_q, sck_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       tick, sample, shift;

  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    edge_d   = edge_q;
    sck_d    = sck_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    tick     = active_q && (div_q == 8'd0);
    done     = tick && (edge_q == 4'd15);
    // edge_q even = leading edge; CPHA=0 samples on leading, CPHA=1 on trailing
    sample   = (edge_q[0] == mode.cpha);
    shift    = !sample && (edge_q != 4'd0) && (edge_q != 4'd15);
    if (load) begin
      tx_d  = load_byte;
      sck_d = mode.cpol;
    end
    if (start) begin
      active_d = 1'b1;
      div_d    = 8'(HALF_DIV - 1);
      edge_d   = 4'd0;
    end else if (active_q) begin
      if (tick) begin
        div_d  = 8'(HALF_DIV - 1);
        edge_d = edge_q + 4'd1;
        sck_d  = ~sck_q;
        if (done) active_d = 1'b0;
        if (sample) rx_d = {rx_q[6:0], sdi};
        else if (shift) tx_d = {tx_q[6:0], 1'b0};
      end else begin
        div_d = div_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= 8'd0;
      edge_q   <= 4'd0;
      sck_q    <= 1'b1;
      tx_q     <= 8'd0;
      rx_q     <= 8'd0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      edge_q   <= edge_d;
      sck_q    <= sck_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  assign sck     = sck_q;
  assign sdo     = tx_q[7];
  assign rx_byte = rx_q;
endmodule

// File: rtl/spi_flash_master.sv
// SPI flash master: runs a whole Read or Write-Byte frame from one valid/ready request.
module spi_flash_master #(
  parameter int          ADDR_W   = 16,
  parameter int          NUM_SS   = 1,
  parameter int          HALF_DIV = 5,
  parameter int          GUARD    = 1,
  parameter int          GAP_CYC  = 2,
  parameter int          RD_WAIT  = 50,
  parameter logic [7:0]  OP_WR    = spi_pkg::OP_WR,
  parameter logic [7:0]  OP_RD    = spi_pkg::OP_RD,
  localparam int         SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  input  logic [1:0]        req_mode,
  input  logic [SS_W-1:0]   req_ss,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              SCK,
  output logic              SDO,
  input  logic              SDI,
  output logic [NUM_SS-1:0] nSS
);
  import spi_pkg::*;

  localparam int         NA       = ADDR_W / 8;
  localparam logic [7:0] LAST     = 8'(NA + 1);
  localparam logic [31:0] GUARD_LD = 32'(GUARD - 1);
  localparam logic [31:0] GAP_LD   = 32'(GAP_CYC * 2 * HALF_DIV - 1);
  localparam logic [31:0] WAIT_LD  = 32'(RD_WAIT * 2 * HALF_DIV - 1);

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [7:0]          byte_q, byte_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  mode_t               mode_q, mode_d;
  logic [SS_W-1:0]     ss_q, ss_d;
  logic [NUM_SS-1:0]   nss_q, nss_d;
  logic                rd_valid_q, rd_valid_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                sh_load, sh_start, sh_done;
  logic [7:0]          sh_rx;

  // Byte 0 is the opcode, then address MSB byte first, then the data byte.
  function automatic logic [7:0] frame_byte(input int idx, input logic wr,
                                            input logic [ADDR_W-1:0] addr,
                                            input logic [7:0] wdata);
    if (idx == 0) return wr ? OP_WR : OP_RD;
    if (idx <= NA) return 8'(addr >> (8 * (NA - idx)));
    return wr ? wdata : 8'h00;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mode_d     = mode_q;
    ss_d       = ss_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    sh_load    = 1'b0;
    sh_start   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (req_valid) begin
        wr_d    = req_wr;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        mode_d  = mode_t'(req_mode);
        ss_d    = req_ss;
        byte_d  = 8'd0;
        cnt_d   = GUARD_LD;
        sh_load = 1'b1;
        state_d = ST_LEAD;
      end
      ST_LEAD: if (cnt_q == 32'd0) begin
        sh_start = 1'b1;
        state_d  = ST_SHIFT;
      end else cnt_d = cnt_q - 32'd1;
      ST_SHIFT: if (sh_done) begin
        cnt_d   = GUARD_LD;
        state_d = ST_TRAIL;
      end
      ST_TRAIL: if (cnt_q == 32'd0) begin
        if (byte_q == LAST) state_d = ST_DONE;
        else begin
          byte_d  = byte_q + 8'd1;
          cnt_d   = GAP_LD;
          state_d = ST_GAP;
        end
      end else cnt_d = cnt_q - 32'd1;
      ST_GAP: if (cnt_q == 32'd0) begin
        if (!wr_q && byte_q == LAST) begin
          cnt_d   = WAIT_LD;
          state_d = ST_WAIT;
        end else begin
          cnt_d   = GUARD_LD;
          sh_load = 1'b1;
          state_d = ST_LEAD;
        end
      end else cnt_d = cnt_q - 32'd1;
      ST_WAIT: if (cnt_q == 32'd0) begin
        cnt_d   = GUARD_LD;
        sh_load = 1'b1;
        state_d = ST_LEAD;
      end else cnt_d = cnt_q - 32'd1;
      ST_DONE: begin
        rd_valid_d = !wr_q;
        if (!wr_q) rd_data_d = sh_rx;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    nss_d = '1;
    if (state_d == ST_LEAD || state_d == ST_SHIFT || state_d == ST_TRAIL)
      for (int i = 0; i < NUM_SS; i++)
        if (ss_d == SS_W'(i)) nss_d[i] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 32'd0;
      byte_q     <= 8'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      mode_q     <= mode_t'(2'b11);
      ss_q       <= '0;
      nss_q      <= '1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mode_q     <= mode_d;
      ss_q       <= ss_d;
      nss_q      <= nss_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  spi_byte_shifter #(.HALF_DIV(HALF_DIV)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_byte (frame_byte(int'(byte_d), wr_d, addr_d, wdata_d)),
    .mode      (mode_d),
    .start     (sh_start),
    .sdi       (SDI),
    .done      (sh_done),
    .sck       (SCK),
    .sdo       (SDO),
    .rx_byte   (sh_rx)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign nSS       = nss_q;
endmodule
